// File: rtl/dsp_pkg.sv
// Shared DSP definitions: output-step indices, the stereo frame type and
// 16-bit saturation.
package dsp_pkg;

  localparam logic [4:0] STEP_OUT_L = 5'd30;
  localparam logic [4:0] STEP_OUT_R = 5'd31;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } stereo_sample_t;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)
      return 16'sh7FFF;
    else if (v < -18'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with an extra pointer bit so full and empty are
// distinguishable; the head word is read combinationally from storage.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // A pop on the same edge frees the slot, so a push into a full FIFO is
  // still accepted when the head is leaving.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '{default: '0};
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/out_mixer.sv
// Final DSP output stage: mixes dry and echo paths with master/echo volume,
// mutes, saturates, and queues stereo frames toward the audio sink.
module out_mixer
  import dsp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OVR_W      = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cpu_en,
  input  logic [4:0]                      step,
  input  logic [7:0]                      mvol_l,
  input  logic [7:0]                      mvol_r,
  input  logic [7:0]                      evol_l,
  input  logic [7:0]                      evol_r,
  input  logic                            mute,
  input  logic [15:0]                     suml_main,
  input  logic [15:0]                     sumr_main,
  input  logic [15:0]                     echo_l,
  input  logic [15:0]                     echo_r,
  output logic [15:0]                     sample_l,
  output logic [15:0]                     sample_r,
  output logic                            sample_valid,
  input  logic                            sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [OVR_W-1:0]                overrun_cnt
);

  // Products are 24 bits wide so -32768 * -128 = +2^22 stays positive after
  // the >>7; bits [23:7] keep the 17-bit signed scaled term.
  function automatic logic signed [15:0] mix(
    input logic signed [15:0] main,
    input logic signed [7:0]  mvol,
    input logic signed [15:0] echo,
    input logic signed [7:0]  evol,
    input logic               mute_in
  );
    logic signed [23:0] pm;
    logic signed [23:0] pe;
    logic signed [16:0] qm;
    logic signed [16:0] qe;
    logic signed [17:0] s;
    pm = main * mvol;
    pe = echo * evol;
    qm = pm[23:7];
    qe = pe[23:7];
    s  = {qm[16], qm} + {qe[16], qe};
    if (mute_in)
      return '0;
    return sat16(s);
  endfunction

  logic signed [15:0] hold_l;
  logic signed [15:0] mix_l;
  logic signed [15:0] mix_r;
  logic               cap_l;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  stereo_sample_t     push_frame;
  stereo_sample_t     head;

  always_comb begin
    mix_l = mix(suml_main, mvol_l, echo_l, evol_l, mute);
    mix_r = mix(sumr_main, mvol_r, echo_r, evol_r, mute);
  end

  assign cap_l = cpu_en && (step == STEP_OUT_L);
  assign push  = cpu_en && (step == STEP_OUT_R);
  assign pop   = sample_valid && sample_ready;

  always_comb begin
    push_frame   = '0;
    push_frame.l = hold_l;
    push_frame.r = mix_r;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_l      <= '0;
      overrun_cnt <= '0;
    end else begin
      if (cap_l)
        hold_l <= mix_l;
      if (push && full && !pop && (overrun_cnt != '1))
        overrun_cnt <= overrun_cnt + 1'b1;
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_frame),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  assign sample_valid = !empty;
  assign sample_l     = head.l;
  assign sample_r     = head.r;

endmodule

// File: tb/tb_out_mixer.sv
// Scoreboard bench for out_mixer: driver queues hand-computed frames, a
// negedge monitor pops and compares on every output handshake.
module tb_out_mixer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_en;
  logic [4:0]  step;
  logic [7:0]  mvol_l, mvol_r, evol_l, evol_r;
  logic        mute;
  logic [15:0] suml_main, sumr_main, echo_l, echo_r;
  logic [15:0] sample_l, sample_r;
  logic        sample_valid;
  logic        sample_ready;
  logic [2:0]  fifo_level;
  logic [7:0]  overrun_cnt;

  logic [31:0] sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_ovr = 0;

  out_mixer #(.FIFO_DEPTH(4), .OVR_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_en       (cpu_en),
    .step         (step),
    .mvol_l       (mvol_l),
    .mvol_r       (mvol_r),
    .evol_l       (evol_l),
    .evol_r       (evol_r),
    .mute         (mute),
    .suml_main    (suml_main),
    .sumr_main    (sumr_main),
    .echo_l       (echo_l),
    .echo_r       (echo_r),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fifo_level   (fifo_level),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at negedge completes on the next posedge.
  always @(negedge clk) begin
    if (reset_n && sample_valid && sample_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame: got %h%h expected none", sample_l, sample_r);
      end else begin
        check("frame", {sample_l, sample_r}, sb.pop_front());
      end
    end
  end

  task automatic cap_left(input logic [15:0] m, input logic [7:0] mv,
                          input logic [15:0] e, input logic [7:0] ev,
                          input logic mu, input logic en);
    @(posedge clk); #1;
    cpu_en = en; step = 5'd30; mute = mu;
    suml_main = m; mvol_l = mv; echo_l = e; evol_l = ev;
  endtask

  task automatic push_right(input logic [15:0] m, input logic [7:0] mv,
                            input logic [15:0] e, input logic [7:0] ev,
                            input logic mu, input logic en, input logic [31:0] exp);
    @(posedge clk); #1;
    cpu_en = en; step = 5'd31; mute = mu;
    sumr_main = m; mvol_r = mv; echo_r = e; evol_r = ev;
    @(posedge clk);
    if (en) begin
      if (sb.size() < 4) sb.push_back(exp);
      else exp_ovr++;
    end
    #1;
    cpu_en = 1'b0; step = 5'd0;
  endtask

  task automatic frame(input logic [15:0] ml, input logic [7:0] mvl,
                       input logic [15:0] el, input logic [7:0] evl,
                       input logic [15:0] mr, input logic [7:0] mvr,
                       input logic [15:0] er, input logic [7:0] evr,
                       input logic mu, input logic [31:0] exp);
    cap_left(ml, mvl, el, evl, mu, 1'b1);
    push_right(mr, mvr, er, evr, mu, 1'b1, exp);
  endtask

  task automatic drain(input string name);
    int i;
    sample_ready = 1'b1;
    for (i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
    check({name, "_valid_low"}, {31'd0, sample_valid}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; cpu_en = 1'b0; step = '0; mute = 1'b0;
    mvol_l = '0; mvol_r = '0; evol_l = '0; evol_r = '0;
    suml_main = '0; sumr_main = '0; echo_l = '0; echo_r = '0;
    sample_ready = 1'b0;
    #22;
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_ovr", {24'd0, overrun_cnt}, 32'd0);
    check("rst_samples", {sample_l, sample_r}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Basic mix, with push latency checks around the step-31 edge
    cap_left(16'h4000, 8'h40, 16'h1000, 8'h40, 1'b0, 1'b1);
    push_right(16'h0000, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b1, 32'h2800_0000);
    check("valid_after_push", {31'd0, sample_valid}, 32'd1);
    check("basic_head", {sample_l, sample_r}, 32'h2800_0000);
    drain("basic");

    // Saturation, corner case, negative volume, mute
    frame(16'h7FFF, 8'h7F, 16'h7FFF, 8'h7F, 16'h8000, 8'h7F, 16'h8000, 8'h7F, 1'b0, 32'h7FFF_8000);
    frame(16'h8000, 8'h80, 16'h0000, 8'h00, 16'h0000, 8'h00, 16'h8000, 8'h80, 1'b0, 32'h7FFF_7FFF);
    frame(16'h1000, 8'hC0, 16'h0000, 8'h00, 16'h0000, 8'h00, 16'h1000, 8'hC0, 1'b0, 32'hF800_F800);
    frame(16'h1234, 8'h40, 16'h7000, 8'h7F, 16'h8000, 8'h80, 16'h4000, 8'h40, 1'b1, 32'h0000_0000);
    drain("mix");

    // cpu_en low on steps 30/31: nothing captured or pushed
    cap_left(16'h4000, 8'h40, 16'h0000, 8'h00, 1'b0, 1'b0);
    push_right(16'h4000, 8'h40, 16'h0000, 8'h00, 1'b0, 1'b0, 32'h0);
    check("no_en_level", {29'd0, fifo_level}, 32'd0);

    // Overrun: six frames with no consumer
    sample_ready = 1'b0;
    for (int k = 1; k <= 6; k++)
      frame(16'(k * 256), 8'h40, 16'h0, 8'h00, 16'(k * 512), 8'h40, 16'h0, 8'h00, 1'b0,
            {16'(k * 128), 16'(k * 256)});
    check("ovr_level", {29'd0, fifo_level}, 32'd4);
    check("ovr_cnt", {24'd0, overrun_cnt}, 32'd2);
    check("ovr_model", 32'(exp_ovr), 32'd2);
    check("ovr_head_f1", {sample_l, sample_r}, 32'h0080_0100);

    // Full FIFO, pop and push on the same edge
    cap_left(16'(7 * 256), 8'h40, 16'h0, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    sample_ready = 1'b1;
    cpu_en = 1'b1; step = 5'd31; sumr_main = 16'(7 * 512); mvol_r = 8'h40;
    echo_r = '0; evol_r = '0;
    @(posedge clk);
    if (sb.size() < 4) sb.push_back(32'h0380_0700); else exp_ovr++;
    #1;
    sample_ready = 1'b0; cpu_en = 1'b0; step = 5'd0;
    check("sim_level", {29'd0, fifo_level}, 32'd4);
    check("sim_ovr", {24'd0, overrun_cnt}, 32'd2);
    check("sim_head_f2", {sample_l, sample_r}, 32'h0100_0200);
    drain("ovr");

    // Reset between step 30 and 31 with two frames queued
    sample_ready = 1'b0;
    frame(16'h0100, 8'h40, 16'h0, 8'h00, 16'h0200, 8'h40, 16'h0, 8'h00, 1'b0, 32'h0080_0100);
    frame(16'h0200, 8'h40, 16'h0, 8'h00, 16'h0400, 8'h40, 16'h0, 8'h00, 1'b0, 32'h0100_0200);
    check("pre_rst_level", {29'd0, fifo_level}, 32'd2);
    cap_left(16'h4000, 8'h40, 16'h0, 8'h00, 1'b0, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, sample_valid}, 32'd0);
    check("mid_rst_level", {29'd0, fifo_level}, 32'd0);
    check("mid_rst_ovr", {24'd0, overrun_cnt}, 32'd0);
    sb.delete();
    exp_ovr = 0;
    cpu_en = 1'b0; step = 5'd0;
    @(posedge clk); #1 reset_n = 1'b1;
    frame(16'h0800, 8'h7F, 16'h0, 8'h00, 16'h0, 8'h00, 16'h0800, 8'h40, 1'b0, 32'h07F0_0400);
    check("post_rst_head", {sample_l, sample_r}, 32'h07F0_0400);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
